// File: rtl/fabric_mem_store_resp_if.sv
// Store-PE-to-memory bundle: address/data input streams, SRAM write port,
// done-token stream and sticky error flags.
interface fabric_mem_store_resp_if #(
  parameter int ELEM_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int TAG_WIDTH      = 0,
  parameter int MEM_ADDR_WIDTH = 10
);
  localparam int ADDR_PW = ADDR_WIDTH + TAG_WIDTH;
  localparam int ELEM_PW = ELEM_WIDTH + TAG_WIDTH;
  localparam int DONE_PW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;

  logic                      in0_valid;
  logic                      in0_ready;
  logic [ADDR_PW-1:0]        in0_data;
  logic                      in1_valid;
  logic                      in1_ready;
  logic [ELEM_PW-1:0]        in1_data;
  logic                      mem_wr_req;
  logic                      mem_wr_ack;
  logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr;
  logic [ELEM_WIDTH-1:0]     mem_wr_data;
  logic                      out0_valid;
  logic                      out0_ready;
  logic [DONE_PW-1:0]        out0_data;
  logic [1:0]                err;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, mem_wr_ack, out0_ready,
    output in0_ready, in1_ready, mem_wr_req, mem_wr_addr, mem_wr_data,
           out0_valid, out0_data, err
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, mem_wr_ack, out0_ready,
    input  in0_ready, in1_ready, mem_wr_req, mem_wr_addr, mem_wr_data,
           out0_valid, out0_data, err
  );
endinterface

// File: rtl/fabric_mem_store_resp.sv
// Memory-side store responder: one SRAM word write per address/data pair, done token per store.
// Optional out-of-bounds retirement enabled by defining FABRIC_MEM_STORE_BOUNDS_CHECK_EN.
module fabric_mem_store_resp #(
  parameter int ELEM_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 64,
  parameter int TAG_WIDTH      = 0,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DONE_DEPTH     = 2
) (
  input logic                    clk,
  input logic                    rst,
  fabric_mem_store_resp_if.slave bus
);
  localparam int DONE_PW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
  localparam int PTR_W   = (DONE_DEPTH > 1) ? $clog2(DONE_DEPTH) : 1;
  localparam int CNT_W   = $clog2(DONE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DONE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DONE_DEPTH);
`ifdef FABRIC_MEM_STORE_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                    state, state_next;
  logic [DONE_PW-1:0]        addr_tag, data_tag, tag_r, push_data;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic [ELEM_WIDTH-1:0]     data_r;
  logic                      req_r;
  logic [1:0]                err_r;
  logic                      addr_high, oob, mismatch, full, can_accept, push, pop;
  logic [DONE_PW-1:0]        fifo [DONE_DEPTH];
  logic [PTR_W-1:0]          head, tail;
  logic [CNT_W-1:0]          count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  generate
    if (TAG_WIDTH > 0) begin : g_tag
      assign addr_tag = bus.in0_data[ADDR_WIDTH +: TAG_WIDTH];
      assign data_tag = bus.in1_data[ELEM_WIDTH +: TAG_WIDTH];
    end else begin : g_notag
      assign addr_tag = 1'b0;
      assign data_tag = 1'b0;
    end
    if (MEM_ADDR_WIDTH < ADDR_WIDTH) begin : g_high
      assign addr_high = |bus.in0_data[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
    end else begin : g_nohigh
      assign addr_high = 1'b0;
    end
  endgenerate

  assign oob      = BOUNDS_EN && addr_high;
  assign mismatch = (addr_tag != data_tag);
  assign full     = (count == CNT_FULL);
  assign pop      = (count != {CNT_W{1'b0}}) && bus.out0_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, capture and done-token push decode
  always_comb begin
    state_next = state;
    can_accept = 1'b0;
    push       = 1'b0;
    push_data  = tag_r;
    case (state)
      IDLE: begin
        can_accept = !rst && bus.in0_valid && bus.in1_valid && !full;
        if (can_accept && !mismatch && oob) begin
          // out-of-bounds store retires immediately without touching memory
          push      = 1'b1;
          push_data = addr_tag;
        end else if (can_accept && !mismatch) begin
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (bus.mem_wr_ack) begin
          push       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WRITE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched write request, address/data/tag and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r  <= 1'b0;
      addr_r <= {MEM_ADDR_WIDTH{1'b0}};
      data_r <= {ELEM_WIDTH{1'b0}};
      tag_r  <= {DONE_PW{1'b0}};
      err_r  <= 2'b00;
    end else begin
      req_r <= (state_next == WRITE);
      if (can_accept) begin
        addr_r <= bus.in0_data[MEM_ADDR_WIDTH-1:0];
        data_r <= bus.in1_data[ELEM_WIDTH-1:0];
        tag_r  <= addr_tag;
        if (mismatch) err_r[0] <= 1'b1;
        else if (oob) err_r[1] <= 1'b1;
      end
    end
  end

  // Done-token circular FIFO; space was reserved at capture so push never overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {CNT_W{1'b0}};
      for (int i = 0; i < DONE_DEPTH; i++) fifo[i] <= {DONE_PW{1'b0}};
    end else begin
      if (push) begin
        fifo[tail] <= push_data;
        tail       <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.in0_ready   = can_accept;
  assign bus.in1_ready   = can_accept;
  assign bus.mem_wr_req  = req_r;
  assign bus.mem_wr_addr = addr_r;
  assign bus.mem_wr_data = data_r;
  assign bus.out0_valid  = (count != {CNT_W{1'b0}});
  assign bus.out0_data   = fifo[head];
  assign bus.err         = err_r;
endmodule

// File: tb/tb_fabric_mem_store_resp.sv
// Directed bench: an untagged responder and a 4-bit-tagged responder driven cycle by cycle.
module tb_fabric_mem_store_resp;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fabric_mem_store_resp_if iu ();
  fabric_mem_store_resp_if #(.TAG_WIDTH(4)) it ();

  fabric_mem_store_resp uu (.clk(clk), .rst(rst), .bus(iu));
  fabric_mem_store_resp #(.TAG_WIDTH(4)) ut (.clk(clk), .rst(rst), .bus(it));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive point: just after the rising edge; check point: the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic upair(input logic [63:0] a, input logic [31:0] d);
    iu.in0_valid = 1'b1; iu.in0_data = a;
    iu.in1_valid = 1'b1; iu.in1_data = d;
  endtask

  task automatic tpair(input logic [3:0] ta, input logic [63:0] a, input logic [3:0] td, input logic [31:0] d);
    it.in0_valid = 1'b1; it.in0_data = {ta, a};
    it.in1_valid = 1'b1; it.in1_data = {td, d};
  endtask

  initial begin
    rst = 1'b1;
    iu.mem_wr_ack = 1'b1; iu.out0_ready = 1'b0;
    it.mem_wr_ack = 1'b1; it.out0_ready = 1'b0;
    it.in0_valid = 1'b0; it.in1_valid = 1'b0; it.in0_data = 68'h0; it.in1_data = 36'h0;
    upair(64'd5, 32'hDEADBEEF);
    cyc(); cyc(); mid();
    chk("rst_ready0", {127'd0, iu.in0_ready}, 128'd0);
    chk("rst_ready1", {127'd0, iu.in1_ready}, 128'd0);
    chk("rst_req", {127'd0, iu.mem_wr_req}, 128'd0);
    chk("rst_addr", {118'd0, iu.mem_wr_addr}, 128'd0);
    chk("rst_data", {96'd0, iu.mem_wr_data}, 128'd0);
    chk("rst_out_valid", {127'd0, iu.out0_valid}, 128'd0);
    chk("rst_out_data", {127'd0, iu.out0_data}, 128'd0);
    chk("rst_err", {126'd0, iu.err}, 128'd0);

    // basic store, ack tied high
    cyc(); rst = 1'b0; mid();
    chk("c0_ready0", {127'd0, iu.in0_ready}, 128'd1);
    chk("c0_ready1", {127'd0, iu.in1_ready}, 128'd1);
    cyc(); iu.in0_valid = 1'b0; iu.in1_valid = 1'b0; mid();
    chk("c1_req", {127'd0, iu.mem_wr_req}, 128'd1);
    chk("c1_addr", {118'd0, iu.mem_wr_addr}, 128'd5);
    chk("c1_data", {96'd0, iu.mem_wr_data}, 128'hDEADBEEF);
    chk("c1_out_valid", {127'd0, iu.out0_valid}, 128'd0);
    cyc(); upair(64'h3FF, 32'h12345678); mid();
    chk("c2_req", {127'd0, iu.mem_wr_req}, 128'd0);
    chk("c2_out_valid", {127'd0, iu.out0_valid}, 128'd1);
    chk("c2_out_data", {127'd0, iu.out0_data}, 128'd0);
    chk("c2_ready", {127'd0, iu.in0_ready}, 128'd1);

    // ack delayed 3 cycles, next pair waiting
    cyc(); iu.mem_wr_ack = 1'b0; upair(64'd7, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) iu.mem_wr_ack = 1'b1;
      mid();
      chk("dly_req", {127'd0, iu.mem_wr_req}, 128'd1);
      chk("dly_addr", {118'd0, iu.mem_wr_addr}, 128'h3FF);
      chk("dly_data", {96'd0, iu.mem_wr_data}, 128'h12345678);
      chk("dly_ready0", {127'd0, iu.in0_ready}, 128'd0);
      chk("dly_ready1", {127'd0, iu.in1_ready}, 128'd0);
      cyc();
    end
    iu.out0_ready = 1'b1; mid();
    chk("c7_full_ready", {127'd0, iu.in0_ready}, 128'd0);
    chk("c7_out_valid", {127'd0, iu.out0_valid}, 128'd1);
    chk("c7_req", {127'd0, iu.mem_wr_req}, 128'd0);
    cyc(); mid();
    chk("c8_ready", {127'd0, iu.in0_ready}, 128'd1);
    chk("c8_out_valid", {127'd0, iu.out0_valid}, 128'd1);
    cyc(); iu.in0_valid = 1'b0; iu.in1_valid = 1'b0; mid();
    chk("c9_req", {127'd0, iu.mem_wr_req}, 128'd1);
    chk("c9_addr", {118'd0, iu.mem_wr_addr}, 128'd7);
    chk("c9_data", {96'd0, iu.mem_wr_data}, 128'hA5A5A5A5);
    chk("c9_out_valid", {127'd0, iu.out0_valid}, 128'd0);
    cyc(); mid();
    chk("c10_out_valid", {127'd0, iu.out0_valid}, 128'd1);
    chk("c10_req", {127'd0, iu.mem_wr_req}, 128'd0);
    cyc(); iu.out0_ready = 1'b0; mid();
    chk("c11_out_valid", {127'd0, iu.out0_valid}, 128'd0);

    // address above the write-port range
    cyc(); upair(64'h400, 32'h11); mid();
    chk("oob_ready", {127'd0, iu.in0_ready}, 128'd1);
    cyc(); iu.in0_valid = 1'b0; iu.in1_valid = 1'b0; mid();
`ifdef FABRIC_MEM_STORE_BOUNDS_CHECK_EN
    chk("oob_req", {127'd0, iu.mem_wr_req}, 128'd0);
    chk("oob_err", {126'd0, iu.err}, 128'd2);
    chk("oob_out_valid", {127'd0, iu.out0_valid}, 128'd1);
    cyc(); mid();
    chk("oob_err_sticky", {126'd0, iu.err}, 128'd2);
`else
    chk("trunc_req", {127'd0, iu.mem_wr_req}, 128'd1);
    chk("trunc_addr", {118'd0, iu.mem_wr_addr}, 128'd0);
    chk("trunc_data", {96'd0, iu.mem_wr_data}, 128'h11);
    chk("trunc_err", {126'd0, iu.err}, 128'd0);
    chk("trunc_out_valid", {127'd0, iu.out0_valid}, 128'd0);
    cyc(); mid();
    chk("trunc_err2", {126'd0, iu.err}, 128'd0);
`endif
    chk("oob_done", {127'd0, iu.out0_valid}, 128'd1);
    chk("oob_req_low", {127'd0, iu.mem_wr_req}, 128'd0);

    // reset mid-WRITE with one token queued
    cyc(); iu.mem_wr_ack = 1'b0; upair(64'd9, 32'h99); mid();
    chk("rw_ready", {127'd0, iu.in0_ready}, 128'd1);
    cyc(); iu.in0_valid = 1'b0; iu.in1_valid = 1'b0; mid();
    chk("rw_req", {127'd0, iu.mem_wr_req}, 128'd1);
    chk("rw_out_valid", {127'd0, iu.out0_valid}, 128'd1);
    cyc(); rst = 1'b1; #1;
    chk("rw_async_req", {127'd0, iu.mem_wr_req}, 128'd0);
    chk("rw_async_out_valid", {127'd0, iu.out0_valid}, 128'd0);
    chk("rw_async_err", {126'd0, iu.err}, 128'd0);
    cyc(); rst = 1'b0; iu.mem_wr_ack = 1'b1; upair(64'h2A, 32'hCAFEF00D); mid();
    chk("post_ready", {127'd0, iu.in0_ready}, 128'd1);
    chk("post_out_valid", {127'd0, iu.out0_valid}, 128'd0);
    cyc(); iu.in0_valid = 1'b0; iu.in1_valid = 1'b0; mid();
    chk("post_req", {127'd0, iu.mem_wr_req}, 128'd1);
    chk("post_addr", {118'd0, iu.mem_wr_addr}, 128'h2A);
    chk("post_data", {96'd0, iu.mem_wr_data}, 128'hCAFEF00D);
    cyc(); iu.out0_ready = 1'b1; mid();
    chk("post_done", {127'd0, iu.out0_valid}, 128'd1);
    chk("post_req_low", {127'd0, iu.mem_wr_req}, 128'd0);
    cyc(); mid();
    chk("post_drained", {127'd0, iu.out0_valid}, 128'd0);

    // tagged: done FIFO backpressure and in-order tokens
    cyc(); tpair(4'd1, 64'd1, 4'd1, 32'h100); mid();
    chk("t0_ready0", {127'd0, it.in0_ready}, 128'd1);
    chk("t0_ready1", {127'd0, it.in1_ready}, 128'd1);
    cyc(); tpair(4'd2, 64'd2, 4'd2, 32'h200); mid();
    chk("t1_req", {127'd0, it.mem_wr_req}, 128'd1);
    chk("t1_addr", {118'd0, it.mem_wr_addr}, 128'd1);
    chk("t1_ready", {127'd0, it.in0_ready}, 128'd0);
    cyc(); mid();
    chk("t2_tok1", {124'd0, it.out0_data}, 128'd1);
    chk("t2_ready", {127'd0, it.in0_ready}, 128'd1);
    cyc(); tpair(4'd3, 64'd3, 4'd3, 32'h300); mid();
    chk("t3_addr", {118'd0, it.mem_wr_addr}, 128'd2);
    chk("t3_ready", {127'd0, it.in0_ready}, 128'd0);
    cyc(); mid();
    chk("t4_full", {127'd0, it.in0_ready}, 128'd0);
    chk("t4_req", {127'd0, it.mem_wr_req}, 128'd0);
    cyc(); it.out0_ready = 1'b1; mid();
    chk("t5_full", {127'd0, it.in1_ready}, 128'd0);
    chk("t5_tok1", {124'd0, it.out0_data}, 128'd1);
    cyc(); mid();
    chk("t6_ready", {127'd0, it.in0_ready}, 128'd1);
    chk("t6_tok2", {124'd0, it.out0_data}, 128'd2);
    cyc(); tpair(4'd4, 64'd4, 4'd4, 32'h400); mid();
    chk("t7_addr", {118'd0, it.mem_wr_addr}, 128'd3);
    chk("t7_empty", {127'd0, it.out0_valid}, 128'd0);
    cyc(); mid();
    chk("t8_tok3", {124'd0, it.out0_data}, 128'd3);
    chk("t8_ready", {127'd0, it.in0_ready}, 128'd1);
    cyc(); it.in0_valid = 1'b0; it.in1_valid = 1'b0; mid();
    chk("t9_req", {127'd0, it.mem_wr_req}, 128'd1);
    chk("t9_data", {96'd0, it.mem_wr_data}, 128'h400);
    cyc(); mid();
    chk("t10_valid", {127'd0, it.out0_valid}, 128'd1);
    chk("t10_tok4", {124'd0, it.out0_data}, 128'd4);

    // tagged: tag mismatch drops the pair
    cyc(); tpair(4'd3, 64'h20, 4'd5, 32'h55); mid();
    chk("mm_empty", {127'd0, it.out0_valid}, 128'd0);
    chk("mm_ready0", {127'd0, it.in0_ready}, 128'd1);
    chk("mm_ready1", {127'd0, it.in1_ready}, 128'd1);
    chk("mm_err_pre", {126'd0, it.err}, 128'd0);
    cyc(); it.in0_valid = 1'b0; it.in1_valid = 1'b0; mid();
    chk("mm_err", {126'd0, it.err}, 128'd1);
    chk("mm_req", {127'd0, it.mem_wr_req}, 128'd0);
    chk("mm_no_tok", {127'd0, it.out0_valid}, 128'd0);
    cyc(); mid();
    chk("mm_err_sticky", {126'd0, it.err}, 128'd1);
    chk("mm_req2", {127'd0, it.mem_wr_req}, 128'd0);
    chk("mm_no_tok2", {127'd0, it.out0_valid}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
